actuator_arbiter: RTL and testbench

ACTUATOR_ARBITER -- requirements
Module: actuator_arbiter

---
 rtl/car_ctrl_pkg.sv | 20 ++
 rtl/arb_picker.sv | 32 +++
 rtl/actuator_arbiter.sv | 158 +++++++++++++++
 tb/tb_actuator_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/car_ctrl_pkg.sv
// Shared definitions for the car control slice: arbiter FSM states,
// requester indices and default sizing for the actuator arbiter.
package car_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2,
        ST_FAULT = 2'd3
    } arb_state_t;

    localparam int EMERG  = 0;
    localparam int DRIVER = 1;
    localparam int CRUISE = 2;

    localparam int DEF_CMD_W     = 8;
    localparam int DEF_MAX_BEATS = 8;
    localparam int DEF_TIMEOUT   = 16;

endpackage

// File: rtl/arb_picker.sv
// Combinational winner selection: emergency brake always wins, driver and
// cruise share the grant round-robin when both ask.
module arb_picker
    import car_ctrl_pkg::*;
(
    input  logic [2:0] req,
    input  logic       rr_cruise_last,
    output logic [2:0] win,
    output logic       win_valid
);

    // rr_cruise_last = 0 means the driver was served last, so cruise wins a tie
    always_comb begin
        win = '0;
        if (req[EMERG]) begin
            win[EMERG] = 1'b1;
        end else if (req[DRIVER] && req[CRUISE]) begin
            if (rr_cruise_last) begin
                win[DRIVER] = 1'b1;
            end else begin
                win[CRUISE] = 1'b1;
            end
        end else if (req[DRIVER]) begin
            win[DRIVER] = 1'b1;
        end else if (req[CRUISE]) begin
            win[CRUISE] = 1'b1;
        end
    end

    assign win_valid = |req;

endmodule

// File: rtl/actuator_arbiter.sv
// Grants one of three requesters access to a single actuator, streaming
// beats with valid/ready, bounded tenures, emergency preemption and a stall watchdog.
module actuator_arbiter
    import car_ctrl_pkg::*;
#(
    parameter int CMD_W     = DEF_CMD_W,
    parameter int MAX_BEATS = DEF_MAX_BEATS,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       req,
    input  logic [CMD_W-1:0] cmd0,
    input  logic [CMD_W-1:0] cmd1,
    input  logic [CMD_W-1:0] cmd2,
    input  logic             act_ready,
    input  logic             clr_fault,
    output logic [2:0]       gnt,
    output logic             act_valid,
    output logic [CMD_W-1:0] act_cmd,
    output logic             fault
);

    localparam int BW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam int SW = $clog2(TIMEOUT + 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BEATS - 1);
    localparam logic [SW-1:0] STALL_LIMIT = SW'(TIMEOUT);

    arb_state_t       state, state_d;
    logic [2:0]       gnt_d;
    logic             valid_d;
    logic [CMD_W-1:0] cmd_d;
    logic             fault_d;
    logic [BW-1:0]    beat_cnt, beat_d;
    logic [SW-1:0]    stall_cnt, stall_d;
    logic             rr_cruise_last, rr_d;

    logic [2:0]       pick_gnt;
    logic             pick_valid;
    logic [CMD_W-1:0] pick_cmd;
    logic [CMD_W-1:0] own_cmd;
    logic             own_req;

    arb_picker u_picker (
        .req            (req),
        .rr_cruise_last (rr_cruise_last),
        .win            (pick_gnt),
        .win_valid      (pick_valid)
    );

    always_comb begin
        pick_cmd = cmd0;
        if (pick_gnt[DRIVER]) begin
            pick_cmd = cmd1;
        end else if (pick_gnt[CRUISE]) begin
            pick_cmd = cmd2;
        end
        own_cmd = cmd0;
        if (gnt[DRIVER]) begin
            own_cmd = cmd1;
        end else if (gnt[CRUISE]) begin
            own_cmd = cmd2;
        end
    end

    assign own_req = |(req & gnt);

    always_comb begin
        state_d = state;
        gnt_d   = gnt;
        valid_d = act_valid;
        cmd_d   = act_cmd;
        fault_d = fault;
        beat_d  = beat_cnt;
        stall_d = stall_cnt;
        rr_d    = rr_cruise_last;
        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_GRANT;
                    gnt_d   = pick_gnt;
                    valid_d = 1'b1;
                    cmd_d   = pick_cmd;
                    beat_d  = '0;
                    stall_d = '0;
                    if (pick_gnt[DRIVER]) begin
                        rr_d = 1'b0;
                    end else if (pick_gnt[CRUISE]) begin
                        rr_d = 1'b1;
                    end
                end
            end
            // The watchdog wins over a handshake arriving in the timeout cycle
            ST_GRANT: begin
                if (stall_cnt == STALL_LIMIT) begin
                    state_d = ST_FAULT;
                    gnt_d   = '0;
                    valid_d = 1'b0;
                    fault_d = 1'b1;
                    beat_d  = '0;
                    stall_d = '0;
                end else if (act_ready) begin
                    stall_d = '0;
                    if (!gnt[EMERG] && req[EMERG]) begin
                        gnt_d  = 3'b001;
                        cmd_d  = cmd0;
                        beat_d = '0;
                    end else if (!own_req || beat_cnt == LAST_BEAT) begin
                        state_d = ST_GAP;
                        gnt_d   = '0;
                        valid_d = 1'b0;
                        beat_d  = '0;
                    end else begin
                        cmd_d  = own_cmd;
                        beat_d = beat_cnt + BW'(1);
                    end
                end else begin
                    stall_d = stall_cnt + SW'(1);
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            ST_FAULT: begin
                if (clr_fault) begin
                    state_d = ST_IDLE;
                    fault_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            gnt            <= '0;
            act_valid      <= 1'b0;
            act_cmd        <= '0;
            fault          <= 1'b0;
            beat_cnt       <= '0;
            stall_cnt      <= '0;
            rr_cruise_last <= 1'b0;
        end else begin
            state          <= state_d;
            gnt            <= gnt_d;
            act_valid      <= valid_d;
            act_cmd        <= cmd_d;
            fault          <= fault_d;
            beat_cnt       <= beat_d;
            stall_cnt      <= stall_d;
            rr_cruise_last <= rr_d;
        end
    end

endmodule

// File: tb/tb_actuator_arbiter.sv
// Directed testbench for actuator_arbiter: arbitration order, tenure limit,
// preemption, stall watchdog, mid-beat request drop and asynchronous reset.
module tb_actuator_arbiter;

    logic       clk;
    logic       rst_n;
    logic [2:0] req;
    logic [7:0] cmd0, cmd1, cmd2;
    logic       act_ready;
    logic       clr_fault;
    logic [2:0] gnt;
    logic       act_valid;
    logic [7:0] act_cmd;
    logic       fault;

    int checks = 0;
    int passed = 0;

    actuator_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .cmd0      (cmd0),
        .cmd1      (cmd1),
        .cmd2      (cmd2),
        .act_ready (act_ready),
        .clr_fault (clr_fault),
        .gnt       (gnt),
        .act_valid (act_valid),
        .act_cmd   (act_cmd),
        .fault     (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        req = 3'b000;
        act_ready = 1'b1;
        while (gnt !== 3'b000 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (gnt !== 3'b000) $display("[TB] FAIL drain_release: gnt=%b after %0d cycles, required 000", gnt, n);
        else passed++;
        tick();
        tick();
        act_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        req = 3'b000; cmd0 = 8'h00; cmd1 = 8'h00; cmd2 = 8'h00;
        act_ready = 1'b0; clr_fault = 1'b0;
        #2 rst_n = 1'b0;
        #10;
        checks++; if (gnt !== 3'b000) $display("[TB] FAIL reset_gnt: got %b, required 000", gnt); else passed++;
        checks++; if (act_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b, required 0", act_valid); else passed++;
        checks++; if (act_cmd !== 8'h00) $display("[TB] FAIL reset_cmd: got %h, required 00", act_cmd); else passed++;
        checks++; if (fault !== 1'b0) $display("[TB] FAIL reset_fault: got %b, required 0", fault); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_round_robin();
        cmd0 = 8'h11; cmd1 = 8'h22; cmd2 = 8'h33;
        req = 3'b110; act_ready = 1'b0;
        tick();
        checks++; if (gnt !== 3'b100) $display("[TB] FAIL rr_first_gnt: got %b, required 100", gnt); else passed++;
        checks++; if (act_cmd !== 8'h33) $display("[TB] FAIL rr_first_cmd: got %h, required 33", act_cmd); else passed++;
        act_ready = 1'b1;
        repeat (8) tick();
        checks++; if (gnt !== 3'b000 || act_valid !== 1'b0) $display("[TB] FAIL rr_gap: gnt=%b valid=%b, required 000/0", gnt, act_valid); else passed++;
        tick();
        tick();
        checks++; if (gnt !== 3'b010) $display("[TB] FAIL rr_second_gnt: got %b, required 010", gnt); else passed++;
        checks++; if (act_cmd !== 8'h22) $display("[TB] FAIL rr_second_cmd: got %h, required 22", act_cmd); else passed++;
        drain();
    endtask

    task automatic test_max_beats();
        int beats;
        int n;
        logic [7:0] nxt;
        cmd1 = 8'h40; req = 3'b010; act_ready = 1'b0;
        tick();
        checks++; if (gnt !== 3'b010) $display("[TB] FAIL mb_grant: got %b, required 010", gnt); else passed++;
        act_ready = 1'b1;
        beats = 0;
        n = 0;
        while (gnt === 3'b010 && n < 20) begin
            beats++;
            nxt = 8'h41 + 8'(n);
            cmd1 = nxt;
            tick();
            n++;
            if (gnt === 3'b010) begin
                checks++;
                if (act_cmd !== nxt) $display("[TB] FAIL mb_recapture: got %h, required %h", act_cmd, nxt);
                else passed++;
            end
        end
        checks++; if (beats != 8) $display("[TB] FAIL mb_beat_count: got %0d, required 8", beats); else passed++;
        checks++; if (gnt !== 3'b000 || act_valid !== 1'b0) $display("[TB] FAIL mb_gap: gnt=%b valid=%b, required 000/0", gnt, act_valid); else passed++;
        tick();
        checks++; if (gnt !== 3'b000) $display("[TB] FAIL mb_idle: got %b, required 000", gnt); else passed++;
        tick();
        checks++; if (gnt !== 3'b010) $display("[TB] FAIL mb_regrant: got %b, required 010", gnt); else passed++;
        drain();
    endtask

    task automatic test_preempt();
        cmd2 = 8'h77; req = 3'b100; act_ready = 1'b0;
        tick();
        checks++; if (gnt !== 3'b100 || act_cmd !== 8'h77) $display("[TB] FAIL pre_grant: gnt=%b cmd=%h, required 100/77", gnt, act_cmd); else passed++;
        req = 3'b101; cmd2 = 8'h78; cmd0 = 8'hE0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (gnt !== 3'b100 || act_cmd !== 8'h77) $display("[TB] FAIL pre_hold: gnt=%b cmd=%h, required 100/77", gnt, act_cmd);
            else passed++;
        end
        act_ready = 1'b1;
        tick();
        checks++; if (gnt !== 3'b001) $display("[TB] FAIL pre_gnt: got %b, required 001", gnt); else passed++;
        checks++; if (act_cmd !== 8'hE0) $display("[TB] FAIL pre_cmd: got %h, required E0", act_cmd); else passed++;
        checks++; if (act_valid !== 1'b1) $display("[TB] FAIL pre_no_gap: valid=%b, required 1", act_valid); else passed++;
        drain();
    endtask

    task automatic test_drop_mid_beat();
        cmd1 = 8'h3C; req = 3'b010; act_ready = 1'b0;
        tick();
        req = 3'b000; cmd1 = 8'h99;
        repeat (2) tick();
        checks++; if (act_valid !== 1'b1 || act_cmd !== 8'h3C) $display("[TB] FAIL drop_pending: valid=%b cmd=%h, required 1/3C", act_valid, act_cmd); else passed++;
        act_ready = 1'b1;
        tick();
        checks++; if (gnt !== 3'b000 || act_valid !== 1'b0) $display("[TB] FAIL drop_gap: gnt=%b valid=%b, required 000/0", gnt, act_valid); else passed++;
        act_ready = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_timeout();
        cmd1 = 8'hC3; req = 3'b010; act_ready = 1'b0;
        tick();
        req = 3'b000;
        repeat (16) tick();
        checks++; if (act_valid !== 1'b1 || fault !== 1'b0) $display("[TB] FAIL to_before: valid=%b fault=%b, required 1/0", act_valid, fault); else passed++;
        tick();
        checks++; if (fault !== 1'b1) $display("[TB] FAIL to_fault: got %b, required 1", fault); else passed++;
        checks++; if (act_valid !== 1'b0 || gnt !== 3'b000) $display("[TB] FAIL to_outputs: valid=%b gnt=%b, required 0/000", act_valid, gnt); else passed++;
        req = 3'b111;
        repeat (3) tick();
        checks++; if (fault !== 1'b1 || gnt !== 3'b000) $display("[TB] FAIL to_sticky: fault=%b gnt=%b, required 1/000", fault, gnt); else passed++;
        clr_fault = 1'b1;
        tick();
        clr_fault = 1'b0;
        checks++; if (fault !== 1'b0 || gnt !== 3'b000) $display("[TB] FAIL to_clear: fault=%b gnt=%b, required 0/000", fault, gnt); else passed++;
        tick();
        checks++; if (gnt !== 3'b001) $display("[TB] FAIL to_after_idle: got %b, required 001", gnt); else passed++;
        drain();
    endtask

    task automatic test_async_reset();
        cmd1 = 8'h5A; req = 3'b010; act_ready = 1'b0;
        tick();
        checks++; if (gnt !== 3'b010 || act_cmd !== 8'h5A) $display("[TB] FAIL ar_setup: gnt=%b cmd=%h, required 010/5A", gnt, act_cmd); else passed++;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (gnt !== 3'b000) $display("[TB] FAIL ar_gnt: got %b, required 000", gnt); else passed++;
        checks++; if (act_valid !== 1'b0) $display("[TB] FAIL ar_valid: got %b, required 0", act_valid); else passed++;
        checks++; if (act_cmd !== 8'h00) $display("[TB] FAIL ar_cmd: got %h, required 00", act_cmd); else passed++;
        checks++; if (fault !== 1'b0) $display("[TB] FAIL ar_fault: got %b, required 0", fault); else passed++;
        @(negedge clk);
        req = 3'b000;
        rst_n = 1'b1;
        tick();
        checks++; if (gnt !== 3'b000) $display("[TB] FAIL ar_idle: got %b, required 000", gnt); else passed++;
    endtask

    initial begin
        $display("[TB] actuator_arbiter directed test start");
        test_reset();
        test_round_robin();
        test_max_beats();
        test_preempt();
        test_drop_mid_beat();
        test_timeout();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
